i2s_dac_tx: RTL and testbench

- Audio output end of the string-voice chain: accepts signed 32-bit samples (the `qout` stream of the voice) over a valid/ready handshake.
- Buffers them in a small FIFO and serialises each one as a standard Philips I2S frame (mono duplicated to left and right) for the external DAC/codec.
- Generates the bit clock and word-select from the system clock; reports FIFO level and underruns.

---
 rtl/i2s_dac_tx.sv | 150 +++++++++++++++
 tb/tb_i2s_dac_tx.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: serialises signed 32-bit mono samples as Philips I2S frames.
// Samples enter through a small first-word-fall-through FIFO; one word is
// popped per 64-bclk frame and sent in both the left and the right slot.
// bclk/lrck are derived from clk and free-run; an empty FIFO at the frame
// boundary sends a silent frame and raises an underrun pulse.
module i2s_dac_tx #(
  parameter int BCLK_DIV    = 4,
  parameter int SAMPLE_BITS = 24,
  parameter int FIFO_AW     = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        in_sample,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               bclk,
  output logic               lrck,
  output logic               sdata,
  output logic               frame_start,
  output logic               underrun,
  output logic [FIFO_AW:0]   fifo_level
);

  localparam int                 Depth     = 2 ** FIFO_AW;
  localparam int                 DivW      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DivW-1:0]    DivLast   = DivW'(BCLK_DIV - 1);
  localparam logic [FIFO_AW:0]   LevelFull = (FIFO_AW + 1)'(Depth);
  // Keeps the SAMPLE_BITS MSBs of a slot; the rest is sent as zero.
  localparam logic [31:0]        KeepMask  = 32'hFFFF_FFFF << (32 - SAMPLE_BITS);

  logic [DivW-1:0]    div_q, div_d;
  logic               bclk_q, bclk_d;
  logic               lrck_q, lrck_d;
  logic               sdata_q, sdata_d;
  logic               fs_q, fs_d;
  logic               ur_q, ur_d;
  logic [5:0]         pos_q, pos_d;
  logic [63:0]        shift_q, shift_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   level_q, level_d;
  logic [31:0]        mem_q [Depth];

  logic        div_end;
  logic        tick;
  logic        pop_slot;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic [31:0] head_word;

  assign div_end    = (div_q == DivLast);
  assign tick       = div_end && bclk_q;          // bclk falling edge
  assign pop_slot   = tick && (pos_q == 6'd63);   // position wraps to 0
  assign fifo_empty = (level_q == '0);
  assign in_ready   = (level_q != LevelFull);
  assign push       = in_valid && in_ready;
  assign pop        = pop_slot && !fifo_empty;
  assign head_word  = mem_q[rd_ptr_q] & KeepMask;

  // Next-state for divider, serialiser and FIFO bookkeeping.
  always_comb begin
    // NOTE: every _d starts as its _q so no path leaves a variable unassigned (no latch).
    div_d    = div_q;
    bclk_d   = bclk_q;
    lrck_d   = lrck_q;
    sdata_d  = sdata_q;
    fs_d     = 1'b0;
    ur_d     = 1'b0;
    pos_d    = pos_q;
    shift_d  = shift_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    if (div_end) begin
      div_d  = '0;
      bclk_d = ~bclk_q;
    end else begin
      div_d  = div_q + DivW'(1);
    end

    if (tick) begin
      pos_d   = pos_q + 6'd1;
      lrck_d  = pos_d[5];
      // The MSB of the shifter goes out one bclk after it was loaded, which
      // gives the I2S one-bit delay and puts the last LSB at position 0.
      sdata_d = shift_q[63];
      if (pop_slot) begin
        fs_d    = 1'b1;
        ur_d    = fifo_empty;
        shift_d = pop ? {head_word, head_word} : '0;
      end else begin
        shift_d = {shift_q[62:0], 1'b0};
      end
    end

    if (push) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + FIFO_AW'(1);

    case ({push, pop})
      2'b10:   level_d = level_q + (FIFO_AW + 1)'(1);
      2'b01:   level_d = level_q - (FIFO_AW + 1)'(1);
      default: level_d = level_q;
    endcase
  end

  // State registers with synchronous reset; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q    <= '0;
      bclk_q   <= 1'b0;
      lrck_q   <= 1'b1;
      sdata_q  <= 1'b0;
      fs_q     <= 1'b0;
      ur_q     <= 1'b0;
      pos_q    <= 6'd63;
      shift_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      div_q    <= div_d;
      bclk_q   <= bclk_d;
      lrck_q   <= lrck_d;
      sdata_q  <= sdata_d;
      fs_q     <= fs_d;
      ur_q     <= ur_d;
      pos_q    <= pos_d;
      shift_q  <= shift_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the pointers and level define which entries are valid.
    if (push) mem_q[wr_ptr_q] <= in_sample;
  end

  assign bclk        = bclk_q;
  assign lrck        = lrck_q;
  assign sdata       = sdata_q;
  assign frame_start = fs_q;
  assign underrun    = ur_q;
  assign fifo_level  = level_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Bench for i2s_dac_tx: two instances (24-bit and 32-bit slots) share one
// stimulus stream and are compared every clk against a frame-level model
// that derives bclk/lrck/position from the clk count since reset release.
module tb_i2s_dac_tx;

  localparam int D     = 2;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in_sample = '0;
  logic        in_valid = 1'b0;

  logic        in_ready_a, bclk_a, lrck_a, sdata_a, fs_a, ur_a;
  logic [AW:0] level_a;
  logic        in_ready_b, bclk_b, lrck_b, sdata_b, fs_b, ur_b;
  logic [AW:0] level_b;

  i2s_dac_tx #(.BCLK_DIV(D), .SAMPLE_BITS(24), .FIFO_AW(AW)) u_dut24 (
    .clk(clk), .reset(reset), .in_sample(in_sample), .in_valid(in_valid),
    .in_ready(in_ready_a), .bclk(bclk_a), .lrck(lrck_a), .sdata(sdata_a),
    .frame_start(fs_a), .underrun(ur_a), .fifo_level(level_a)
  );

  i2s_dac_tx #(.BCLK_DIV(D), .SAMPLE_BITS(32), .FIFO_AW(AW)) u_dut32 (
    .clk(clk), .reset(reset), .in_sample(in_sample), .in_valid(in_valid),
    .in_ready(in_ready_b), .bclk(bclk_b), .lrck(lrck_b), .sdata(sdata_b),
    .frame_start(fs_b), .underrun(ur_b), .fifo_level(level_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int          n = 0;          // clk edges since reset release
  logic [31:0] q[$];           // queued words
  logic [31:0] cur_w = '0;     // word of the frame being sent (0 = silent)
  logic [31:0] prev_w = '0;    // word of the previous frame
  int          e_p = 63;
  logic        e_bclk = 1'b0, e_lrck = 1'b1, e_fs = 1'b0, e_ur = 1'b0, e_ready = 1'b1;
  int          e_level = 0;
  logic        m_accept = 1'b0;

  function automatic logic [63:0] frame_of(logic [31:0] w, int sb);
    logic [31:0] t;
    t = (w >> (32 - sb)) << (32 - sb);
    return {t, t};
  endfunction

  function automatic logic exp_sdata(int sb);
    logic [63:0] f;
    if (e_p == 0) begin
      f = frame_of(prev_w, sb);
      return f[0];
    end
    f = frame_of(cur_w, sb);
    return f[64 - e_p];
  endfunction

  function automatic bit next_is_pop();
    int m;
    m = n + 1;
    return (m % (2 * D) == 0) && (((63 + m / (2 * D)) % 64) == 0);
  endfunction

  task automatic model_edge();
    int pre;
    bit ready_before;
    bit pop_now;
    if (reset) begin
      n = 0;
      q.delete();
      cur_w = '0;
      prev_w = '0;
      m_accept = 1'b0;
      e_fs = 1'b0;
      e_ur = 1'b0;
    end else begin
      pre = q.size();
      ready_before = (pre != DEPTH);
      n++;
      pop_now = (n % (2 * D) == 0) && (((63 + n / (2 * D)) % 64) == 0);
      e_fs = pop_now;
      e_ur = pop_now && (pre == 0);
      if (pop_now) begin
        prev_w = cur_w;
        cur_w = (pre > 0) ? q.pop_front() : 32'h0;
      end
      m_accept = in_valid && ready_before;
      if (m_accept) q.push_back(in_sample);
    end
    e_p     = (63 + n / (2 * D)) % 64;
    e_bclk  = ((n / D) % 2) == 1;
    e_lrck  = (e_p >= 32);
    e_level = q.size();
    e_ready = (q.size() != DEPTH);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (n=%0d)", tag, obs, exp, n);
    end
  endtask

  task automatic compare_all();
    check("a.bclk",  32'(bclk_a),     32'(e_bclk));
    check("a.lrck",  32'(lrck_a),     32'(e_lrck));
    check("a.sdata", 32'(sdata_a),    32'(exp_sdata(24)));
    check("a.fs",    32'(fs_a),       32'(e_fs));
    check("a.ur",    32'(ur_a),       32'(e_ur));
    check("a.level", 32'(level_a),    32'(e_level));
    check("a.ready", 32'(in_ready_a), 32'(e_ready));
    check("b.bclk",  32'(bclk_b),     32'(e_bclk));
    check("b.lrck",  32'(lrck_b),     32'(e_lrck));
    check("b.sdata", 32'(sdata_b),    32'(exp_sdata(32)));
    check("b.fs",    32'(fs_b),       32'(e_fs));
    check("b.ur",    32'(ur_b),       32'(e_ur));
    check("b.level", 32'(level_b),    32'(e_level));
    check("b.ready", 32'(in_ready_b), 32'(e_ready));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(input int k);
    in_valid = 1'b0;
    for (int i = 0; i < k; i++) cycle();
  endtask

  initial begin
    logic [31:0] words [9];
    int idx;
    int guard;
    int accept9_n;

    // Power-up reset, then idle: silent frames with one underrun per frame.
    reset = 1'b1;
    repeat (3) cycle();
    check("rst.bclk",  32'(bclk_a),     32'd0);
    check("rst.lrck",  32'(lrck_a),     32'd1);
    check("rst.sdata", 32'(sdata_a),    32'd0);
    check("rst.level", 32'(level_a),    32'd0);
    check("rst.ready", 32'(in_ready_a), 32'd1);
    reset = 1'b0;
    run(4);
    check("idle.first_fs", 32'(fs_a), 32'd1);
    check("idle.first_ur", 32'(ur_a), 32'd1);
    run(526);

    // Two words pushed before the first tick; truncation and LSB delay.
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    in_valid = 1'b1;
    in_sample = 32'h8000_00FF;
    cycle();
    in_sample = 32'h7FFF_FFFF;
    cycle();
    run(514);
    check("lsb.p0_sb32", 32'(sdata_b), 32'd1);
    check("lsb.p0_sb24", 32'(sdata_a), 32'd0);
    check("lsb.ur",      32'(ur_a),    32'd1);
    run(300);

    // Fill the FIFO by holding in_valid; the ninth word waits for a pop.
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    run(4);
    for (int i = 0; i < 9; i++) words[i] = {8'(i + 1), 24'($urandom)};
    idx = 0;
    guard = 0;
    accept9_n = -1;
    while (idx < 9 && guard < 1000) begin
      in_valid = 1'b1;
      in_sample = words[idx];
      cycle();
      if (m_accept) begin
        idx++;
        if (idx == 8) begin
          check("fill.level8", 32'(level_a),    32'd8);
          check("fill.ready0", 32'(in_ready_a), 32'd0);
        end
        if (idx == 9) accept9_n = n;
      end
      guard++;
    end
    check("fill.all_accepted", 32'(idx), 32'd9);
    check("fill.accept9_n",    32'(accept9_n), 32'd261);
    run(2400);

    // Push exactly on a frame-start edge with the FIFO empty.
    guard = 0;
    while (!next_is_pop() && guard < 600) begin
      cycle();
      guard++;
    end
    in_valid = 1'b1;
    in_sample = $urandom;
    cycle();
    in_valid = 1'b0;
    check("race.ur",    32'(ur_a),    32'd1);
    check("race.level", 32'(level_a), 32'd1);
    run(520);

    // Reset in the middle of the right slot with words still queued.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_sample = $urandom;
      cycle();
    end
    in_valid = 1'b0;
    guard = 0;
    while (e_p != 40 && guard < 600) begin
      cycle();
      guard++;
    end
    check("mid.reached_p40", 32'(e_p), 32'd40);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("mid.bclk",  32'(bclk_a),     32'd0);
    check("mid.lrck",  32'(lrck_a),     32'd1);
    check("mid.sdata", 32'(sdata_a),    32'd0);
    check("mid.level", 32'(level_a),    32'd0);
    check("mid.ready", 32'(in_ready_a), 32'd1);
    run(600);

    // Random traffic at slow, idle and bursty rates.
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 1000; i++) begin
        case (ph)
          0:       in_valid = ($urandom_range(0, 299) == 0);
          1:       in_valid = ($urandom_range(0, 99) < 5);
          2:       in_valid = 1'b0;
          default: in_valid = ($urandom_range(0, 199) < 2);
        endcase
        in_sample = $urandom;
        cycle();
      end
    end
    in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
